uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit-side controller and serializer for the UART TX path.
- Accepts a parallel data word, runs the frame state machine (start, data, optional parity, stop), and shifts the data out LSB first.
- Computes the parity bit and drives the 2-bit select of the downstream registered output mux.
- Mux select encoding: 00 = start bit (0), 01 = stop/idle (1), 10 = serial data, 11 = parity.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous reset, active-low
- P_DATA  input  WIDTH  parallel word to transmit
- DATA_VALID  input  1  single-cycle or held request; sampled only in IDLE
- PAR_EN  input  1  1 = parity bit inserted after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- MUX_SEL  output  2  select to TX output mux
- SER_DATA  output  1  current data bit (valid while MUX_SEL=10)
- PAR_BIT  output  1  frame parity bit (valid while MUX_SEL=11)
- BUSY  output  1  high from START through STOP inclusive

Behaviour:
- Reset: RST low at a rising CLK edge gives state=IDLE, MUX_SEL=01, SER_DATA=0, PAR_BIT=0, BUSY=0, bit counter=0, shift register=0. Reset is synchronous; it has no effect between edges.
- Reset mid-frame: the frame is abandoned and the block is in IDLE after that edge. No partial completion.
- All outputs are registered (Moore) and change only on CLK edges.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - MUX_SEL=01, BUSY=0.
  - If DATA_VALID=1 at edge k: latch P_DATA into shift register, latch PAR_EN and PAR_TYP, and compute PAR_BIT from the latched word.
  - After edge k: state=START, MUX_SEL=00, BUSY=1.
- START: one cycle, MUX_SEL=00. Next state DATA with SER_DATA=data[0], counter=0.
- DATA:
  - MUX_SEL=10. Each edge shifts right (SER_DATA presents the next bit) and increments the counter.
  - After exactly WIDTH cycles in DATA: go to PARITY if latched PAR_EN=1, else STOP.
  - The counter never wraps mid-frame; it is cleared on entry to DATA.
- PARITY: one cycle, MUX_SEL=11, PAR_BIT held. Next state STOP.
- STOP:
  - One cycle, MUX_SEL=01, BUSY=1. Next state IDLE (BUSY=0).
  - DATA_VALID in STOP is ignored, so there is at least one IDLE cycle between frames.
- Parity arithmetic:
  - Even: PAR_BIT = XOR-reduce of the data word.
  - Odd: PAR_BIT = inverse of that.
  - PAR_BIT holds its value until the next accepted frame.
- Input changes during a frame: DATA_VALID, P_DATA, PAR_EN and PAR_TYP changes while BUSY=1 have no effect on the current frame.
- Frame length in MUX_SEL cycles: 1 + WIDTH + PAR_EN + 1.
- The downstream mux adds one register stage, so the line level lags MUX_SEL by one cycle. The controller does not compensate for this.
- Back-to-back frames: with DATA_VALID held high, a new frame is accepted on the first IDLE edge after each STOP. Period = frame length + 1 cycle.

Test Plan:
- WIDTH=8, P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> MUX_SEL sequence 00, 10x8, 01 then IDLE. SER_DATA sequence 1,0,1,0,0,1,0,1. BUSY high for exactly 10 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> PARITY state present, PAR_BIT=0, BUSY high 11 cycles. Repeat with PAR_TYP=1 -> PAR_BIT=1. P_DATA=0x07 even -> PAR_BIT=1.
- DATA_VALID pulsed with P_DATA=0xFF during the DATA state of a 0x00 frame -> current frame shifts all zeros and the pulse is dropped. After the frame, MUX_SEL stays 01 and BUSY stays 0.
- RST low for one edge while in DATA at bit 3 -> next cycle MUX_SEL=01, BUSY=0, SER_DATA=0, PAR_BIT=0. A subsequent DATA_VALID starts a clean frame from START.
- DATA_VALID held high, words 0x3C then 0xC3 (changed during the first frame), PAR_EN=1 even -> two complete frames separated by exactly one IDLE cycle. The second frame carries 0xC3 with PAR_BIT=0.
- WIDTH=5, P_DATA=5'b10110, PAR_EN=1 odd -> 5 DATA cycles, SER_DATA 0,1,1,0,1, PAR_BIT=0, BUSY high 8 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// UART TX controller bus: parallel request in, mux select and
// serial/parity/busy status out.
interface uart_tx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [1:0]       MUX_SEL;
  logic             SER_DATA;
  logic             PAR_BIT;
  logic             BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  MUX_SEL, SER_DATA, PAR_BIT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output MUX_SEL, SER_DATA, PAR_BIT, BUSY
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start, LSB-first data, optional
// parity, stop. All outputs registered.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input logic          CLK,
  input logic          RST,
  uart_tx_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_en_q;
  logic [1:0]       mux_sel;
  logic             ser_data;
  logic             par_bit;
  logic             busy;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      par_en_q <= 1'b0;
      mux_sel  <= SEL_STOP;
      ser_data <= 1'b0;
      par_bit  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.DATA_VALID) begin
            shreg    <= bus.P_DATA;
            par_en_q <= bus.PAR_EN;
            par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
            state    <= START;
            mux_sel  <= SEL_START;
            busy     <= 1'b1;
          end
        end
        START: begin
          ser_data <= shreg[0];
          shreg    <= shreg >> 1;
          cnt      <= '0;
          state    <= DATA;
          mux_sel  <= SEL_DATA;
        end
        DATA: begin
          if (cnt == CW'(WIDTH - 1)) begin
            if (par_en_q) begin
              state   <= PARITY;
              mux_sel <= SEL_PAR;
            end else begin
              state   <= STOP;
              mux_sel <= SEL_STOP;
            end
          end else begin
            ser_data <= shreg[0];
            shreg    <= shreg >> 1;
            cnt      <= cnt + CW'(1);
          end
        end
        PARITY: begin
          state   <= STOP;
          mux_sel <= SEL_STOP;
        end
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mux_sel <= SEL_STOP;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MUX_SEL  = mux_sel;
  assign bus.SER_DATA = ser_data;
  assign bus.PAR_BIT  = par_bit;
  assign bus.BUSY     = busy;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: frame records queued by
// stimulus, reassembled and checked by a negedge monitor.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(8)) if8 ();
  uart_tx_ctrl_if #(.WIDTH(5)) if5 ();

  uart_tx_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .bus(if8.slave)
  );
  uart_tx_ctrl #(.WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst_n), .bus(if5.slave)
  );

  typedef struct {
    logic [8:0] data;
    int         ndata;
    bit         par_seen;
    logic       par_val;
    int         busy_len;
    bit         stop_seen;
    int         gap;
  } rec_t;

  rec_t q8[$];
  rec_t q5[$];

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  bit         in_f[2];
  int         phase[2];
  int         dcnt[2];
  int         blen[2];
  int         idle[2];
  int         mgap[2];
  logic [8:0] dbits[2];
  bit         pseen[2];
  bit         sseen[2];
  bit         serr[2];
  bit         had[2];
  logic       pval[2];

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic frame_done(int id);
    rec_t e;
    string p;
    p = (id == 0) ? "w8" : "w5";
    tests++;
    if ((id == 0 && q8.size() == 0) || (id == 1 && q5.size() == 0)) begin
      fails++;
      $display("FAIL %s unexpected_frame: got 1 expected 0", p);
      return;
    end
    tests--;
    e = (id == 0) ? q8.pop_front() : q5.pop_front();
    chk({p, " data"}, int'(dbits[id]), int'(e.data));
    chk({p, " ndata"}, dcnt[id], e.ndata);
    chk({p, " par_seen"}, int'(pseen[id]), int'(e.par_seen));
    if (e.par_seen)
      chk({p, " par_bit"}, int'(pval[id]), int'(e.par_val));
    chk({p, " busy_len"}, blen[id], e.busy_len);
    chk({p, " stop_seen"}, int'(sseen[id]), int'(e.stop_seen));
    chk({p, " mux_order"}, int'(serr[id]), 0);
    if (e.gap >= 0)
      chk({p, " idle_gap"}, mgap[id], e.gap);
  endtask

  task automatic mon_step(int id, logic [1:0] ms, logic sd,
                          logic pb, logic bz);
    if (!in_f[id]) begin
      if (bz === 1'b1 && ms === 2'b00) begin
        in_f[id]  = 1'b1;
        mgap[id]  = had[id] ? idle[id] : -1;
        phase[id] = 0;
        dcnt[id]  = 0;
        blen[id]  = 1;
        dbits[id] = '0;
        pseen[id] = 1'b0;
        sseen[id] = 1'b0;
        serr[id]  = 1'b0;
        pval[id]  = 1'b0;
      end else begin
        idle[id]++;
      end
    end else if (bz === 1'b1) begin
      blen[id]++;
      case (ms)
        2'b00: serr[id] = 1'b1;
        2'b10: begin
          if (phase[id] > 1) serr[id] = 1'b1;
          if (dcnt[id] < 9) dbits[id][dcnt[id]] = sd;
          dcnt[id]++;
          phase[id] = 1;
        end
        2'b11: begin
          if (phase[id] > 2) serr[id] = 1'b1;
          pseen[id] = 1'b1;
          pval[id]  = pb;
          phase[id] = 2;
        end
        default: begin
          sseen[id] = 1'b1;
          phase[id] = 3;
        end
      endcase
    end else begin
      in_f[id] = 1'b0;
      had[id]  = 1'b1;
      idle[id] = 1;
      frame_done(id);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_step(0, if8.MUX_SEL, if8.SER_DATA, if8.PAR_BIT, if8.BUSY);
      mon_step(1, if5.MUX_SEL, if5.SER_DATA, if5.PAR_BIT, if5.BUSY);
    end
  end

  task automatic wait_edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic rec_t mk(logic [8:0] d, int nd, bit ps,
                              logic pv, int bl, bit ss, int g);
    rec_t r;
    r.data = d; r.ndata = nd; r.par_seen = ps; r.par_val = pv;
    r.busy_len = bl; r.stop_seen = ss; r.gap = g;
    return r;
  endfunction

  task automatic wait_idle8(string nm);
    int n;
    n = 0;
    while (if8.BUSY === 1'b1 && n < 40) begin
      wait_edges(1);
      n++;
    end
    if (n >= 40) chk({nm, " timeout"}, 1, 0);
    wait_edges(2);
  endtask

  task automatic send8(logic [7:0] d, bit pe, bit pt, string nm);
    if8.P_DATA = d; if8.PAR_EN = pe; if8.PAR_TYP = pt;
    if8.DATA_VALID = 1'b1;
    wait_edges(1);
    if8.DATA_VALID = 1'b0;
    wait_idle8(nm);
  endtask

  task automatic chk_idle8(string nm);
    @(negedge clk);
    chk({nm, " mux_sel"}, int'(if8.MUX_SEL), 1);
    chk({nm, " busy"}, int'(if8.BUSY), 0);
    #1;
  endtask

  initial begin
    if8.P_DATA = '0; if8.DATA_VALID = 1'b0;
    if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0;
    if5.P_DATA = '0; if5.DATA_VALID = 1'b0;
    if5.PAR_EN = 1'b0; if5.PAR_TYP = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_f[i] = 1'b0; had[i] = 1'b0; idle[i] = 0;
    end

    wait_edges(2);
    @(negedge clk);
    chk("rst mux_sel", int'(if8.MUX_SEL), 1);
    chk("rst busy", int'(if8.BUSY), 0);
    chk("rst ser_data", int'(if8.SER_DATA), 0);
    chk("rst par_bit", int'(if8.PAR_BIT), 0);
    chk("rst5 mux_sel", int'(if5.MUX_SEL), 1);
    #1;
    rst_n = 1'b1;
    mon_on = 1'b1;
    wait_edges(2);

    q8.push_back(mk(9'h0A5, 8, 0, 1'b0, 10, 1, -1));
    send8(8'hA5, 1'b0, 1'b0, "a5_nopar");
    q8.push_back(mk(9'h0A5, 8, 1, 1'b0, 11, 1, -1));
    send8(8'hA5, 1'b1, 1'b0, "a5_even");
    q8.push_back(mk(9'h0A5, 8, 1, 1'b1, 11, 1, -1));
    send8(8'hA5, 1'b1, 1'b1, "a5_odd");
    q8.push_back(mk(9'h007, 8, 1, 1'b1, 11, 1, -1));
    send8(8'h07, 1'b1, 1'b0, "07_even");

    // Request and config changes mid-frame must not leak in.
    q8.push_back(mk(9'h000, 8, 0, 1'b0, 10, 1, -1));
    if8.P_DATA = 8'h00; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0;
    if8.DATA_VALID = 1'b1;
    wait_edges(1);
    if8.DATA_VALID = 1'b0;
    wait_edges(3);
    if8.P_DATA = 8'hFF; if8.PAR_EN = 1'b1; if8.DATA_VALID = 1'b1;
    wait_edges(1);
    if8.DATA_VALID = 1'b0;
    wait_idle8("drop");
    chk_idle8("drop_after1");
    wait_edges(3);
    chk_idle8("drop_after2");

    // Reset while bit 3 is on the line.
    q8.push_back(mk(9'h00A, 4, 0, 1'b0, 5, 0, -1));
    if8.P_DATA = 8'h5A; if8.PAR_EN = 1'b1; if8.PAR_TYP = 1'b1;
    if8.DATA_VALID = 1'b1;
    wait_edges(1);
    if8.DATA_VALID = 1'b0;
    wait_edges(4);
    @(negedge clk);
    chk("pre_rst ser_data", int'(if8.SER_DATA), 1);
    chk("pre_rst par_bit", int'(if8.PAR_BIT), 1);
    #1;
    rst_n = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst mux_sel", int'(if8.MUX_SEL), 1);
    chk("mid_rst busy", int'(if8.BUSY), 0);
    chk("mid_rst ser_data", int'(if8.SER_DATA), 0);
    chk("mid_rst par_bit", int'(if8.PAR_BIT), 0);
    #1;
    wait_edges(2);
    q8.push_back(mk(9'h081, 8, 0, 1'b0, 10, 1, -1));
    send8(8'h81, 1'b0, 1'b0, "post_rst");

    // Held request: back-to-back frames, one idle cycle apart.
    q8.push_back(mk(9'h03C, 8, 1, 1'b0, 11, 1, -1));
    q8.push_back(mk(9'h0C3, 8, 1, 1'b0, 11, 1, 1));
    if8.P_DATA = 8'h3C; if8.PAR_EN = 1'b1; if8.PAR_TYP = 1'b0;
    if8.DATA_VALID = 1'b1;
    wait_edges(1);
    wait_edges(3);
    if8.P_DATA = 8'hC3;
    wait_edges(10);
    if8.DATA_VALID = 1'b0;
    wait_idle8("b2b");

    q5.push_back(mk(9'h016, 5, 1, 1'b0, 8, 1, -1));
    if5.P_DATA = 5'b10110; if5.PAR_EN = 1'b1; if5.PAR_TYP = 1'b1;
    if5.DATA_VALID = 1'b1;
    wait_edges(1);
    if5.DATA_VALID = 1'b0;
    begin
      int n;
      n = 0;
      while (if5.BUSY === 1'b1 && n < 40) begin
        wait_edges(1);
        n++;
      end
      if (n >= 40) chk("w5 timeout", 1, 0);
    end
    wait_edges(3);

    chk("q8 drained", q8.size(), 0);
    chk("q5 drained", q5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
